// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL lock sequencer: FSM state encoding and retry counter width.
package pll_seq_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // metastability filter: capture then re-register
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: reset pulse, lock wait with timeout, stability qualification, bounded retries.
// Build option: define PLL_AUTO_RELOCK_EN to retry on lock loss in RUN instead of faulting immediately.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_W               = 16
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         state
);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    logic               lk_s;
    pll_state_e         state_r;
    pll_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               cnt_adv_s;
    logic [RETRY_W-1:0] retry_r;
    logic [RETRY_W-1:0] retry_nxt_s;
    logic               pll_rst_r;
    logic               sys_rst_n_r;
    logic               ready_r;
    logic               fault_r;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    // next-state, retry accounting and counter advance; relock_req overrides every transition
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_r;
        cnt_adv_s   = 1'b0;
        if (relock_req) begin
            state_nxt_s = RESET;
            retry_nxt_s = {RETRY_W{1'b0}};
        end else begin
            case (state_r)
                RESET: begin
                    cnt_adv_s = 1'b1;
                    if (cnt_r == HOLD_LAST) begin
                        state_nxt_s = WAIT_LOCK;
                    end else begin
                        state_nxt_s = RESET;
                    end
                end
                WAIT_LOCK: begin
                    cnt_adv_s = 1'b1;
                    if (lk_s) begin
                        state_nxt_s = STABLE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        if (retry_r < RETRY_MAX) begin
                            state_nxt_s = RESET;
                            retry_nxt_s = retry_r + RETRY_W'(1);
                        end else begin
                            state_nxt_s = FAULT;
                        end
                    end else begin
                        state_nxt_s = WAIT_LOCK;
                    end
                end
                STABLE: begin
                    cnt_adv_s = 1'b1;
                    if (!lk_s) begin
                        state_nxt_s = WAIT_LOCK;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = STABLE;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
`ifdef PLL_AUTO_RELOCK_EN
                        if (retry_r < RETRY_MAX) begin
                            state_nxt_s = RESET;
                            retry_nxt_s = retry_r + RETRY_W'(1);
                        end else begin
                            state_nxt_s = FAULT;
                        end
`else
                        state_nxt_s = FAULT;
`endif
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                FAULT: begin
                    state_nxt_s = FAULT;
                end
                default: begin
                    state_nxt_s = RESET;
                end
            endcase
        end

        // terminal compares force a state change before the counter could wrap
        if (relock_req || (state_nxt_s != state_r)) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_adv_s) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // state, counters and output registers; outputs are decoded from the state being entered
    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_r     <= RESET;
            cnt_r       <= {CNT_W{1'b0}};
            retry_r     <= {RETRY_W{1'b0}};
            pll_rst_r   <= 1'b1;
            sys_rst_n_r <= 1'b0;
            ready_r     <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            retry_r     <= retry_nxt_s;
            pll_rst_r   <= (state_nxt_s == RESET);
            // rises one cycle after RUN is entered, drops on the same edge that leaves RUN
            sys_rst_n_r <= (state_r == RUN) && (state_nxt_s == RUN);
            ready_r     <= (state_nxt_s == RUN);
            fault_r     <= (state_nxt_s == FAULT);
        end
    end

    assign pll_rst   = pll_rst_r;
    assign sys_rst_n = sys_rst_n_r;
    assign ready     = ready_r;
    assign fault     = fault_r;
    assign retry_cnt = retry_r;
    assign state     = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: expected output changes (with their cycle) are queued by the
// stimulus; a monitor compares every observed output change against the queue head.
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state;

    typedef struct {
        int          cyc;
        string       name;
        logic [10:0] snap;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_r = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   finish_req = 1'b0;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2),
        .CNT_W               (16)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // rising-edge count; an output change caused by edge k is seen at the negedge where cyc_r == k
    always @(posedge refclk) cyc_r <= cyc_r + 1;

    function automatic void push_exp(input int c, input string nm, input pll_state_e st,
                                     input logic pr, input logic sr, input logic rd,
                                     input logic ft, input logic [3:0] rc);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.snap = {st, pr, sr, rd, ft, rc};
        exp_q.push_back(e);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc_r < n) @(negedge refclk);
    endtask

    // monitor: every change of the output bundle is one transaction checked against the queue head
    initial begin
        logic [10:0] prev_snap;
        logic [10:0] snap;
        exp_t        e;
        prev_snap = 11'bx;
        forever begin
            @(negedge refclk);
            snap = {state, pll_rst, sys_rst_n, ready, fault, retry_cnt};
            if (snap !== prev_snap) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got cyc=%0d st/rst/sys/rdy/flt/retry=%h, required no change",
                             cyc_r, snap);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc_r || e.snap !== snap) begin
                        n_bad++;
                        $display("FAIL %s: got cyc=%0d st/rst/sys/rdy/flt/retry=%h, required cyc=%0d %h",
                                 e.name, cyc_r, snap, e.cyc, e.snap);
                    end
                end
            end else if (exp_q.size() != 0 && cyc_r > exp_q[0].cyc) begin
                e = exp_q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL %s: got no change by cyc=%0d (outputs %h), required cyc=%0d %h",
                         e.name, cyc_r, snap, e.cyc, e.snap);
            end
            prev_snap = snap;
            if (finish_req) begin
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover: got %0d pending expectations, required 0", exp_q.size());
                end
                $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
                $finish;
            end
        end
    end

    // stimulus: directed scenario with hand-derived change cycles
    initial begin
        rst        = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        push_exp(1, "reset_state", RESET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(7, "rst_hold_4", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(3);
        rst = 1'b1;

        // lock 5 cycles into WAIT_LOCK, 2-cycle sync lag, 8 stable cycles
        wait_cyc(11);
        pll_locked = 1'b1;
        push_exp(14, "enter_stable", STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(22, "enter_run", RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        push_exp(23, "sys_rst_release", RUN, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // lock loss in RUN
        wait_cyc(30);
        pll_locked = 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
        push_exp(33, "run_loss_relock", RESET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
`else
        push_exp(33, "run_loss_fault", FAULT, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
`endif
        wait_cyc(33);
        rst = 1'b0;
        push_exp(34, "rst_after_loss", RESET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // no lock: three timed-out attempts then FAULT
        wait_cyc(34);
        rst = 1'b1;
        push_exp(38,  "attempt0_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(58,  "timeout0",      RESET,     1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        push_exp(62,  "attempt1_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        push_exp(82,  "timeout1",      RESET,     1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        push_exp(86,  "attempt2_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        push_exp(106, "timeout_fault", FAULT,     1'b0, 1'b0, 1'b0, 1'b1, 4'd2);

        // relock_req out of FAULT
        wait_cyc(110);
        relock_req = 1'b1;
        push_exp(111, "relock_from_fault", RESET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(115, "relock_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(111);
        relock_req = 1'b0;

        // one-cycle lock glitch at STABLE count 5, then full requalification
        wait_cyc(119);
        pll_locked = 1'b1;
        push_exp(122, "stable_again", STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(125);
        pll_locked = 1'b0;
        push_exp(128, "glitch_to_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(129, "glitch_restable", STABLE, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(137, "requal_run", RUN, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        push_exp(138, "requal_sys_rst", RUN, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        wait_cyc(126);
        pll_locked = 1'b1;

        // relock_req coincides with lock loss in RUN: relock wins, retry_cnt stays 0
        wait_cyc(145);
        pll_locked = 1'b0;
        wait_cyc(147);
        relock_req = 1'b1;
        push_exp(148, "relock_beats_loss", RESET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        push_exp(152, "relock_wait2", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(148);
        relock_req = 1'b0;

        // rst mid-WAIT_LOCK
        wait_cyc(157);
        rst = 1'b0;
        push_exp(158, "rst_mid_wait", RESET, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        wait_cyc(158);
        rst = 1'b1;
        push_exp(162, "post_rst_wait", WAIT_LOCK, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        wait_cyc(170);
        finish_req = 1'b1;
    end

    // watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, required completion");
        $fatal(1);
    end

endmodule
